// File: rtl/pipeline_acc_pkg.sv
// Shared types and helpers for the product accumulator family.
// Holds the frame state enum, saturation bounds and sign extension.
package pipeline_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    function automatic longint acc_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint acc_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Sign-extend the low w bits of v to 64 bits.
    function automatic longint sign_ext(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

endpackage

// File: rtl/pipeline_product_accumulator_module_acc_add_sat.sv
// Combinational W-bit signed adder with overflow detect.
// PIPELINE_ACC_SAT_EN clamps overflowing sums instead of wrapping.
module acc_add_sat
    import pipeline_acc_pkg::*;
#(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] raw;

    assign raw = a + b;
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef PIPELINE_ACC_SAT_EN
    localparam logic [W-1:0] SAT_MAX = W'(acc_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(acc_min(W));

    // Clamp direction follows the operand sign (both operands agree on overflow).
    assign sum = ovf ? (b[W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/pipeline_product_accumulator_module.sv
// Sums LEN consecutive signed products into a held valid/ready result.
// Build with PIPELINE_ACC_SAT_EN for saturating instead of wrapping adds.
module pipeline_product_accumulator_module
    import pipeline_acc_pkg::*;
#(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 20,
    parameter int LEN    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CW = $clog2(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    acc_state_t      state;
    logic [CW-1:0]   cnt;
    logic [ACC_W-1:0] acc;
    logic            ovf_s;

    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [ACC_W-1:0] sum_next;
    logic             ovf_next;
    logic             accept;
    logic             first;

    assign x = ACC_W'(sign_ext(longint'(product), PROD_W));

    acc_add_sat #(
        .W(ACC_W)
    ) u_add (
        .a  (acc),
        .b  (x),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign first    = (cnt == '0);
    assign sum_next = first ? x : add_sum;
    assign ovf_next = first ? 1'b0 : (ovf_s | add_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            cnt       <= '0;
            acc       <= '0;
            ovf_s     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            // Abort wins over any coincident product or pending result.
            state     <= ACCUM;
            cnt       <= '0;
            ovf_s     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc   <= sum_next;
                        ovf_s <= ovf_next;
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            out_sum   <= sum_next;
                            out_ovf   <= ovf_next;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_product_accumulator_module.sv
// Directed bench for the product accumulator.
// Second instance runs at ACC_W=16 to exercise overflow handling.
module tb_pipeline_product_accumulator_module;

    logic        clk = 1'b0;
    logic        rst;

    logic        clr;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        in_ready;
    logic        out_valid;
    logic        out_ovf;
    logic [19:0] out_sum;

    logic        b_clr;
    logic        b_in_valid;
    logic        b_out_ready;
    logic [15:0] b_product;
    logic        b_in_ready;
    logic        b_out_valid;
    logic        b_out_ovf;
    logic [15:0] b_out_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_product_accumulator_module #(
        .PROD_W(16), .ACC_W(20), .LEN(8)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .product  (product),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf)
    );

    pipeline_product_accumulator_module #(
        .PROD_W(16), .ACC_W(16), .LEN(8)
    ) u_d16 (
        .clk      (clk),
        .rst      (rst),
        .clr      (b_clr),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .product  (b_product),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_sum  (b_out_sum),
        .out_ovf  (b_out_ovf)
    );

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input int v);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            product  = 16'(v);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; product = '0;
        b_clr = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_product = '0;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", $signed(out_sum), 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_b_out_valid", b_out_valid, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Mixed-sign frame, back-to-back
        feed(1, 510);
        feed(1, -1180);
        feed(1, -16129);
        in_valid = 1'b1; product = 16'd0;
        for (int i = 0; i < 4; i++) tick();
        chk("mix_no_early_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("mix_valid", out_valid, 1);
        chk("mix_sum", $signed(out_sum), -16799);
        chk("mix_ovf", out_ovf, 0);
        chk("mix_hold_ready", in_ready, 0);

        // Back-pressure with the source pushing 7s
        in_valid = 1'b1; product = 16'd7;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum_stable", $signed(out_sum), -16799);
            chk("bp_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        feed(7, 7);
        chk("bp_f2_no_early", out_valid, 0);
        feed(1, 7);
        chk("bp_f2_valid", out_valid, 1);
        chk("bp_f2_sum", $signed(out_sum), 56);
        take();

        // Extreme products
        feed(8, 16384);
        chk("pos_sum", $signed(out_sum), 131072);
        chk("pos_ovf", out_ovf, 0);
        take();
        feed(8, -16256);
        chk("neg_sum", $signed(out_sum), -130048);
        chk("neg_ovf", out_ovf, 0);
        take();

        // clr after 3 accepts
        feed(3, 100);
        clr = 1'b1; tick(); clr = 1'b0;
        feed(7, 1);
        chk("clr_no_early", out_valid, 0);
        feed(1, 1);
        chk("clr_valid", out_valid, 1);
        chk("clr_sum", $signed(out_sum), 8);
        take();

        // clr coincident with a valid product
        feed(3, 1);
        clr = 1'b1; in_valid = 1'b1; product = 16'd1000;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        feed(7, 2);
        chk("clrv_no_early", out_valid, 0);
        feed(1, 2);
        chk("clrv_sum", $signed(out_sum), 16);
        take();

        // clr during HOLD discards the pending sum
        feed(8, 3);
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", $signed(out_sum), 24);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_hold_valid", out_valid, 0);
        chk("clr_hold_ready", in_ready, 1);
        feed(8, 5);
        chk("after_clr_sum", $signed(out_sum), 40);
        chk("after_clr_ovf", out_ovf, 0);
        take();

        // Async reset mid-frame, between edges
        feed(3, 9);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_sum", $signed(out_sum), 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        #2;
        rst = 1'b0;
        tick();

        // Frame with idle gaps: 1+2+...+8
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) chk("gap_no_early", out_valid, 0);
            in_valid = 1'b1; product = 16'(i);
            tick();
            in_valid = 1'b0;
            tick();
        end
        chk("gap_valid", out_valid, 1);
        chk("gap_sum", $signed(out_sum), 36);
        take();

        // Overflow on the 16-bit accumulator
        b_in_valid = 1'b1; b_product = 16'd16129;
        for (int i = 0; i < 8; i++) tick();
        b_in_valid = 1'b0;
        chk("ovf_valid", b_out_valid, 1);
        chk("ovf_flag", b_out_ovf, 1);
`ifdef PIPELINE_ACC_SAT_EN
        chk("ovf_sum", $signed(b_out_sum), 32767);
`else
        chk("ovf_sum", $signed(b_out_sum), -2040);
`endif
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
        chk("ovf_release", b_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_product_accumulator_module.md
Name: pipeline_product_accumulator_module

Overview:
- Downstream consumer of the pipelined 8x8 signed LUT multiplier.
- Takes the 16-bit signed product stream and sums each group of LEN consecutive valid products, forming a dot-product / MAC frame.
- Presents the signed sum on a valid/ready output port.
- Holds the result until it is accepted, and back-pressures the product source meanwhile.

Parameters:
- PROD_W, 16, signed product width; matches the multiplier output.
- ACC_W, 20, signed accumulator and result width; must be >= PROD_W + clog2(LEN).
- LEN, 8, products per frame; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous frame abort.
- in_valid  in  1  product is valid this cycle, aligned to the multiplier output latency.
- in_ready  out  1  block accepts a product this cycle.
- product  in  PROD_W  signed product.
- out_valid  out  1  sum is valid and held.
- out_ready  in  1  downstream accepts the sum.
- out_sum  out  ACC_W  signed frame sum.
- out_ovf  out  1  overflow occurred somewhere in the reported frame.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While asserted:
  - state=ACCUM, cnt=0, acc=0;
  - out_valid=0, out_sum=0, out_ovf=0;
  - in_ready=1 as soon as rst deasserts.
- Acceptance: a product is taken when in_valid && in_ready. Input `x = sign_extend(product, ACC_W)`.
- State ACCUM (in_ready=1):
  - On accept with cnt==0: acc <= x, ovf_s <= 0.
  - On accept with cnt>0: acc <= acc + x. ovf_s |= (signs of acc and x equal, and sign of sum differs).
  - cnt increments modulo LEN.
  - On accepting the cnt==LEN-1 product: out_sum <= final sum, out_ovf <= final ovf_s, out_valid <= 1, cnt <= 0, state <= HOLD.
  - Latency: out_valid rises the cycle after the LEN-th accept.
- State HOLD (in_ready=0):
  - out_sum and out_ovf stay stable.
  - Products presented while in HOLD are not consumed; the upstream must stall or drop them.
  - On out_ready: out_valid <= 0, state <= ACCUM. A new frame can start the next cycle, so there is one bubble per frame.
- in_ready is a registered-state decode only; it has no combinational path from out_ready.
- clr in either state:
  - cnt <= 0, ovf_s <= 0, out_valid <= 0, state <= ACCUM;
  - a pending unaccepted sum is discarded.
- clr with simultaneous in_valid: clr wins and the product is discarded.
- Idle cycles: in_valid=0 cycles inside a frame leave acc and cnt unchanged; gaps are allowed.
- Arithmetic: two's complement, ACC_W bits. Without the optional feature, overflow wraps.
- Reset mid-frame: partial sum is lost; no output is produced.

Optional Feature:
- Macro: PIPELINE_ACC_SAT_EN.
- Defined: on overflow each add clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) by the operand sign. Saturation is sticky across the rest of the frame's adds (ordinary arithmetic resumes from the clamped value). out_ovf is still set.
- Undefined: modular wrap; out_ovf is set identically.

Decomposition:
- Shared package pipeline_acc_pkg holds:
  - state enum {ACCUM, HOLD};
  - ACC_MAX/ACC_MIN constant functions of ACC_W;
  - sign-extend helper.
- One natural sub-module: acc_add_sat. It is a combinational ACC_W adder with overflow detect and macro-guarded clamp, reused by the future MAC variants.

Test Plan:
- Mixed signs: LEN=8, ACC_W=20. Products 510, -1180, -16129, then 5 zeros, back-to-back -> out_sum = -16799 (0xFBE61), out_ovf=0. out_valid rises the cycle after the 8th accept.
- Back-pressure: same frame, out_ready held low 10 cycles, in_valid held high with product=7:
  - in_ready stays 0 and out_sum is stable for all 10 cycles;
  - after out_ready, the next frame of 8×7 -> 56.
- Overflow: ACC_W=16 override, 8 × 16129 -> out_ovf=1. out_sum = -2040 without macro; 32767 with PIPELINE_ACC_SAT_EN.
- Extreme negatives: 8 × (+16384) (-128×-128) at ACC_W=20 -> 131072, no overflow. 8 × (-16256) -> -130048.
- clr:
  - clr after 3 accepts, then 8 × 1 -> out_sum=8;
  - clr coincident with in_valid drops that sample;
  - clr during HOLD drops out_valid next cycle.
- Async reset: assert rst mid-frame between clock edges -> outputs zero immediately with no clock. Then a frame with idle gaps (in_valid toggling) sums correctly.
